// File: rtl/instruction_encoder_pkg.sv
// Shared opcode constants, field positions, format/state enums and the opcode classifier.
// ENCODER_FLOAT_EN makes ADDF/MULF legal R-type opcodes; without it they are illegal.
package instruction_encoder_pkg;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_MOVE  = 6'd5;
    localparam logic [5:0] OP_SGE   = 6'd6;
    localparam logic [5:0] OP_SLE   = 6'd7;
    localparam logic [5:0] OP_SGT   = 6'd8;
    localparam logic [5:0] OP_SLT   = 6'd9;
    localparam logic [5:0] OP_SEQ   = 6'd10;
    localparam logic [5:0] OP_SNE   = 6'd11;
    localparam logic [5:0] OP_AND   = 6'd12;
    localparam logic [5:0] OP_OR    = 6'd13;
    localparam logic [5:0] OP_XOR   = 6'd14;
    localparam logic [5:0] OP_NOT   = 6'd15;
    localparam logic [5:0] OP_MOVEI = 6'd16;
    localparam logic [5:0] OP_SLI   = 6'd17;
    localparam logic [5:0] OP_SRI   = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SUBI  = 6'd20;
    localparam logic [5:0] OP_JUMP  = 6'd21;
    localparam logic [5:0] OP_BRA   = 6'd22;
    localparam logic [5:0] OP_ADDF  = 6'd23;
    localparam logic [5:0] OP_MULF  = 6'd24;

    localparam int OPC_LSB  = 26;
    localparam int RS1_LSB  = 21;
    localparam int F2_LSB   = 16;
    localparam int RD_R_LSB = 11;
    localparam int OPC_W    = 6;
    localparam int REG_W    = 5;
    localparam int IMM16_W  = 16;
    localparam int IMM26_W  = 26;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_MV, FMT_MVI, FMT_J, FMT_BR, FMT_ST, FMT_NOP} fmt_e;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_e;

    typedef struct packed {
        logic legal;
        fmt_e fmt;
    } op_class_t;

    function automatic op_class_t classify(input logic [5:0] op);
        op_class_t c;
        c.legal = 1'b1;
        c.fmt   = FMT_NOP;
        case (op)
            OP_NOP: c.fmt = FMT_NOP;
            OP_ADD, OP_SUB, OP_SGE, OP_SLE, OP_SGT, OP_SLT,
            OP_SEQ, OP_SNE, OP_AND, OP_OR, OP_XOR: c.fmt = FMT_R;
            OP_LOAD, OP_SLI, OP_SRI, OP_ADDI, OP_SUBI: c.fmt = FMT_I;
            OP_MOVE, OP_NOT: c.fmt = FMT_MV;
            OP_MOVEI: c.fmt = FMT_MVI;
            OP_JUMP:  c.fmt = FMT_J;
            OP_BRA:   c.fmt = FMT_BR;
            OP_STORE: c.fmt = FMT_ST;
`ifdef ENCODER_FLOAT_EN
            OP_ADDF, OP_MULF: c.fmt = FMT_R;
`endif
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Instruction beat input, memory write port and status bundle of the instruction encoder.
interface instruction_encoder_if #(parameter int ADDR_W = 8);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              in_valid;
    logic              in_last;
    logic [5:0]        opcode;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [4:0]        rs_value;
    logic [15:0]       imm16;
    logic [25:0]       imm26;
    logic              in_ready;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic              illegal_err;
    logic              wrap_err;
    logic [ADDR_W:0]   word_cnt;
    logic              err_clear;

    modport master (
        output start, start_addr, in_valid, in_last, opcode, rs1, rs2, rd, rs_value,
               imm16, imm26, wr_ready, err_clear,
        input  in_ready, wr_valid, wr_addr, wr_data, busy, done, illegal_err, wrap_err, word_cnt
    );

    modport slave (
        input  start, start_addr, in_valid, in_last, opcode, rs1, rs2, rd, rs_value,
               imm16, imm26, wr_ready, err_clear,
        output in_ready, wr_valid, wr_addr, wr_data, busy, done, illegal_err, wrap_err, word_cnt
    );
endinterface

// File: rtl/instruction_encoder_fifo.sv
// Two-entry 32-bit word FIFO between the encoder and the memory write port.
module instr_word_fifo (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic [31:0] head_o,
    output logic        full_o,
    output logic        empty_o
);
    logic [31:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        push_ok;
    logic        pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: the occupancy count alone defines what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded instruction beats into 32-bit words and streams them to instruction memory.
// ENCODER_FLOAT_EN (see package) enables the ADDF/MULF opcodes.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    instruction_encoder_if.slave  bus
);
    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic              illegal_q;
    logic              wrap_q;
    logic              done_q;

    op_class_t   cls;
    logic [31:0] word_d;
    logic        in_ready;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;

    assign cls      = classify(bus.opcode);
    assign in_ready = (state_q == ST_LOAD) && !fifo_full;
    assign accept   = bus.in_valid && in_ready;
    assign push     = accept && cls.legal;
    assign pop      = !fifo_empty && bus.wr_ready;

    always_comb begin
        word_d = '0;
        word_d[OPC_LSB +: OPC_W] = bus.opcode;
        case (cls.fmt)
            FMT_R: begin
                word_d[RS1_LSB  +: REG_W] = bus.rs1;
                word_d[F2_LSB   +: REG_W] = bus.rs2;
                word_d[RD_R_LSB +: REG_W] = bus.rd;
            end
            FMT_I: begin
                word_d[RS1_LSB +: REG_W]   = bus.rs1;
                word_d[F2_LSB  +: REG_W]   = bus.rd;
                word_d[0 +: IMM16_W]       = bus.imm16;
            end
            FMT_MV: begin
                word_d[RS1_LSB +: REG_W] = bus.rs1;
                word_d[F2_LSB  +: REG_W] = bus.rd;
            end
            FMT_MVI: begin
                word_d[F2_LSB +: REG_W] = bus.rd;
                word_d[0 +: IMM16_W]    = bus.imm16;
            end
            FMT_J: word_d[0 +: IMM26_W] = bus.imm26;
            FMT_BR: begin
                word_d[RS1_LSB +: REG_W] = bus.rs1;
                word_d[F2_LSB  +: REG_W] = bus.rs_value;
                word_d[0 +: IMM16_W]     = bus.imm16;
            end
            FMT_ST: begin
                word_d[RS1_LSB +: REG_W] = bus.rs1;
                word_d[F2_LSB  +: REG_W] = bus.rs2;
                word_d[0 +: IMM16_W]     = bus.imm16;
            end
            default: word_d = '0;
        endcase
    end

    instr_word_fifo u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (word_d),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            word_cnt_q <= '0;
            illegal_q  <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    state_q    <= ST_LOAD;
                    addr_q     <= bus.start_addr;
                    word_cnt_q <= '0;
                end
                ST_LOAD: if (accept && bus.in_last) state_q <= ST_DRAIN;
                ST_DRAIN: if (fifo_empty) begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
            // The FIFO is always empty in IDLE, so a pop never collides with a start load.
            if (pop) begin
                addr_q     <= addr_q + 1'b1;
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            illegal_q <= (accept && !cls.legal) || (illegal_q && !bus.err_clear);
            wrap_q    <= (pop && (&addr_q)) || (wrap_q && !bus.err_clear);
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.wr_valid    = !fifo_empty;
    assign bus.wr_data     = fifo_head;
    assign bus.wr_addr     = addr_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.illegal_err = illegal_q;
    assign bus.wrap_err    = wrap_q;
    assign bus.word_cnt    = word_cnt_q;
endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have ports `clock` (in, 1): single clock; `reset_n` (in, 1): asynchronous, active-low reset.
REQ-003 SHALL have input `start` (1): one-cycle pulse that opens a program load, and input `start_addr` (ADDR_W): base word address for that load.
REQ-004 SHALL have inputs `in_valid` (1), `in_last` (1), `opcode` (6), `rs1`/`rs2`/`rd`/`rs_value` (5 each), `imm16` (16) and `imm26` (26): one decoded instruction per beat.
REQ-005 SHALL have output `in_ready` (1); a beat is accepted when `in_valid` && `in_ready`.
REQ-006 SHALL have memory write port outputs `wr_valid` (1), `wr_addr` (ADDR_W) and `wr_data` (32), plus input `wr_ready` (1).
REQ-007 SHALL have outputs `busy` (1), `done` (1-cycle pulse), `illegal_err` (sticky), `wrap_err` (sticky), `word_cnt` (ADDR_W+1) and input `err_clear` (1).

Function
REQ-008 FSM SHALL have three states: IDLE, LOAD and DRAIN.
REQ-009 IDLE -> LOAD on `start`, loading the address counter with `start_addr` and zeroing `word_cnt`.
REQ-010 In IDLE and DRAIN `in_ready` SHALL be 0; in LOAD `in_ready` = output FIFO not full.
REQ-011 LOAD -> DRAIN on an accepted beat with `in_last`=1.
REQ-012 DRAIN -> IDLE when the FIFO is empty; `done` SHALL pulse for one cycle on that transition.
REQ-013 `start` outside IDLE SHALL be ignored.
REQ-014 Packing, with unlisted bits zero and bits [31:26] = opcode in every case:
  - R-type (ADD 1, SUB 2, SGE..XOR 6,7,8,9,10,11,12,13,14): rs1[25:21], rs2[20:16], rd[15:11].
  - I-type (LOAD 4, SLI 17, SRI 18, ADDI 19, SUBI 20): rs1[25:21], rd[20:16], imm16[15:0].
  - MOVE 5, NOT 15: rs1[25:21], rd[20:16].
  - MOVEI 16: rd[20:16], imm16.
  - JUMP 21: imm26[25:0].
  - BRA 22: rs1[25:21], rs_value[20:16], imm16.
  - STORE 3: rs1[25:21], rs2[20:16], imm16.
  - NOP 0: all-zero word.
REQ-015 An accepted legal beat SHALL be pushed into a 2-entry FIFO at the accepting edge, so `wr_valid` can rise the next cycle (latency 1).
REQ-016 An accepted illegal opcode (25..63, or 23/24 when floating point is disabled) SHALL NOT be pushed; it SHALL set `illegal_err`, and `in_last` on that beat still SHALL take effect.
REQ-017 `wr_valid` = FIFO non-empty; `wr_data` = FIFO head; `wr_addr` = address counter.
REQ-018 On `wr_valid` && `wr_ready` the FIFO SHALL pop, the address counter SHALL increment, and `word_cnt` SHALL increment.
REQ-019 `wr_valid` and `wr_data` SHALL be held stable while `wr_ready`=0.
REQ-020 Address increment from all-ones SHALL wrap to 0 and set `wrap_err`; writing continues.
REQ-021 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged; with the FIFO full and popping, `in_ready` SHALL be 0 that cycle (registered-full ready).
REQ-022 `err_clear` SHALL clear both sticky flags; a setting event in the same cycle SHALL win.
REQ-023 `busy` = state != IDLE.

Reset
REQ-024 While `reset_n`=0 the block SHALL be in IDLE with the FIFO empty, address counter 0, `word_cnt` 0 and `wr_valid`/`in_ready`/`done`/`busy`/`illegal_err`/`wrap_err` 0.
REQ-025 Reset asserted mid-load SHALL discard buffered words with no further write.

Configuration
REQ-026 Macro ENCODER_FLOAT_EN controls floating-point opcodes.
REQ-027 When ENCODER_FLOAT_EN is defined, ADDF 23 and MULF 24 SHALL be legal and packed as R-type.
REQ-028 When ENCODER_FLOAT_EN is undefined, ADDF 23 and MULF 24 SHALL be illegal per REQ-016.

Structure
REQ-029 A shared package SHALL hold the opcode constants (NOP..MULF), the field bit positions, the format enum (R, I, MV, MVI, J, BR, ST, NOP) and the FSM state enum.
REQ-030 Sub-module `instr_word_fifo` (2-entry, 32-bit, push/pop/full/empty) SHALL implement the FIFO; encoding and FSM stay in the top level.

Verification
REQ-031 start, start_addr=0x10; ADD rs1=1, rs2=2, rd=3, last -> one write addr 0x10, data 0x04221800; then done pulse; word_cnt=1.
REQ-032 ADDI rs1=4, rd=5, imm16=0xFFFF; then JUMP imm26=0x0000123 -> data 0x4C85FFFF at addr N, then 0x54000123 at addr N+1.
REQ-033 wr_ready held 0 for 5 cycles while 4 beats are offered -> in_ready drops after 2 accepts, wr_data stable; on release, all 4 words are written in order.
REQ-034 opcode 30 between two NOPs -> illegal_err=1, exactly two zero words written, word_cnt=2; err_clear -> illegal_err=0.
REQ-035 start_addr=0xFF with 2 beats (ADDR_W=8) -> writes at 0xFF then 0x00, wrap_err=1.
REQ-036 ADDF rs1=1, rs2=2, rd=3 -> 0x5C221800 written when ENCODER_FLOAT_EN is defined; nothing written and illegal_err=1 otherwise. reset_n low mid-DRAIN -> wr_valid=0 immediately, state IDLE.
